// File: rtl/endian_swap_arbiter_if.sv
// Bundle of handshake and bus signals for endian_swap_arbiter.
//   req0_* / req1_* : two requester beat streams (valid, data, swap, last, ready)
//   out_*           : single registered output beat stream (valid, data, src, last, ready)
// slave  : arbiter side (consumes requests, produces the output stream)
// master : environment side (produces requests, consumes the output stream)
interface endian_swap_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid_i;
    logic [DATA_W-1:0] req0_data_i;
    logic              req0_swap_i;
    logic              req0_last_i;
    logic              req0_ready_o;

    logic              req1_valid_i;
    logic [DATA_W-1:0] req1_data_i;
    logic              req1_swap_i;
    logic              req1_last_i;
    logic              req1_ready_o;

    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_src_o;
    logic              out_last_o;
    logic              out_ready_i;

    modport slave (
        input  req0_valid_i, req0_data_i, req0_swap_i, req0_last_i,
        output req0_ready_o,
        input  req1_valid_i, req1_data_i, req1_swap_i, req1_last_i,
        output req1_ready_o,
        output out_valid_o, out_data_o, out_src_o, out_last_o,
        input  out_ready_i
    );

    modport master (
        output req0_valid_i, req0_data_i, req0_swap_i, req0_last_i,
        input  req0_ready_o,
        output req1_valid_i, req1_data_i, req1_swap_i, req1_last_i,
        input  req1_ready_o,
        input  out_valid_o, out_data_o, out_src_o, out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/endian_swap_arbiter.sv
// Two-requester arbiter sharing one byte-reversal datapath.
// Grants round-robin at packet granularity, locks the grant until the
// packet's last beat is accepted, and converts each beat (byte reverse or
// pass-through, chosen per beat) as it enters a single output register.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : endian_swap_arbiter_if.slave (request streams in, output stream out)
module endian_swap_arbiter #(
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 reset,
    endian_swap_arbiter_if.slave bus
);

    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    // Byte k of the result is byte (NBYTES-1-k) of the input.
    function automatic logic [DATA_W-1:0] byte_reverse(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = {DATA_W{1'b0}};
        for (int k = 0; k < NBYTES; k++) begin
            r[8*k +: 8] = d[8*(NBYTES-1-k) +: 8];
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic              out_last_q, out_last_d;

    logic              stage_free_s;
    logic              grant_s;
    logic              grant_vld_s;
    logic              sel_valid_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_swap_s;
    logic              sel_last_s;
    logic              accept_s;

    // The output register can take a beat when empty or draining this cycle.
    assign stage_free_s = ~out_valid_q | bus.out_ready_i;

    // Grant selection: round-robin in IDLE, fixed owner while a packet is locked.
    always_comb begin
        grant_s     = 1'b0;
        grant_vld_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0_valid_i && bus.req1_valid_i) begin
                    grant_s     = ~last_grant_q;
                    grant_vld_s = 1'b1;
                end else if (bus.req0_valid_i) begin
                    grant_s     = 1'b0;
                    grant_vld_s = 1'b1;
                end else if (bus.req1_valid_i) begin
                    grant_s     = 1'b1;
                    grant_vld_s = 1'b1;
                end else begin
                    grant_s     = 1'b0;
                    grant_vld_s = 1'b0;
                end
            end
            // Owner keeps the grant even while idle, so mid-packet bubbles never let the other side in.
            ST_LOCK0: begin
                grant_s     = 1'b0;
                grant_vld_s = 1'b1;
            end
            ST_LOCK1: begin
                grant_s     = 1'b1;
                grant_vld_s = 1'b1;
            end
            default: begin
                grant_s     = 1'b0;
                grant_vld_s = 1'b0;
            end
        endcase
    end

    // Mux the granted requester's beat onto the shared datapath.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = {DATA_W{1'b0}};
        sel_swap_s  = 1'b0;
        sel_last_s  = 1'b0;
        if (grant_s) begin
            sel_valid_s = bus.req1_valid_i;
            sel_data_s  = bus.req1_data_i;
            sel_swap_s  = bus.req1_swap_i;
            sel_last_s  = bus.req1_last_i;
        end else begin
            sel_valid_s = bus.req0_valid_i;
            sel_data_s  = bus.req0_data_i;
            sel_swap_s  = bus.req0_swap_i;
            sel_last_s  = bus.req0_last_i;
        end
    end

    assign bus.req0_ready_o = stage_free_s & grant_vld_s & ~grant_s;
    assign bus.req1_ready_o = stage_free_s & grant_vld_s & grant_s;
    assign accept_s         = stage_free_s & grant_vld_s & sel_valid_s;

    // Next FSM state and round-robin pointer, advanced only by accepted beats.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (accept_s) begin
            last_grant_d = grant_s;
            if (sel_last_s) begin
                state_d = ST_IDLE;
            end else if (grant_s) begin
                state_d = ST_LOCK1;
            end else begin
                state_d = ST_LOCK0;
            end
        end else if ((state_q == ST_IDLE) || (state_q == ST_LOCK0) || (state_q == ST_LOCK1)) begin
            state_d = state_q;
        end else begin
            // Recover from an unreachable encoding.
            state_d = ST_IDLE;
        end
    end

    // Output register next values: load on accept, clear valid on drain, hold otherwise.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (stage_free_s) begin
            out_valid_d = accept_s;
            if (accept_s) begin
                out_data_d = sel_swap_s ? byte_reverse(sel_data_s) : sel_data_s;
                out_src_d  = grant_s;
                out_last_d = sel_last_s;
            end else begin
                out_data_d = out_data_q;
                out_src_d  = out_src_q;
                out_last_d = out_last_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_W{1'b0}};
            out_src_q    <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_src_o   = out_src_q;
    assign bus.out_last_o  = out_last_q;

endmodule

// File: tb/tb_endian_swap_arbiter.sv
// Self-checking bench for endian_swap_arbiter: directed scenarios with literal
// expectations, then randomized packet traffic checked by a cycle model and a
// per-requester packet scoreboard.
module tb_endian_swap_arbiter;
    localparam int DW   = 32;
    localparam int NBEAT = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    endian_swap_arbiter_if #(.DATA_W(DW)) bus ();
    endian_swap_arbiter #(.DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass = 0;
    int n_total = 0;

    // Reference model state: who holds the packet lock (-1 none), last winner, output register image.
    int            m_lock = -1;
    logic          m_last = 1'b1;
    logic          m_ov = 1'b0;
    logic [DW-1:0] m_od = '0;
    logic          m_os = 1'b0;
    logic          m_ol = 1'b0;

    logic          fire0 = 1'b0, fire1 = 1'b0;
    logic          sb_en = 1'b0;
    logic [DW:0]   exp_q0[$];
    logic [DW:0]   exp_q1[$];

    logic [DW-1:0] bd[2][NBEAT];
    logic          bs[2][NBEAT];
    logic          bl[2][NBEAT];
    int            idx0 = 0, idx1 = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reverse the byte order arithmetically: lowest input byte ends up on top.
    function automatic logic [DW-1:0] rev(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW/8; i++) r = (r << 8) | ((d >> (8*i)) & 32'hFF);
        return r;
    endfunction

    // Cycle-by-cycle compare against the model, scoreboard, then model advance.
    always @(negedge clk) begin
        logic v[2]; logic [DW-1:0] d[2]; logic s[2]; logic l[2];
        logic sf; int own; logic [DW:0] e;
        v[0] = bus.req0_valid_i; d[0] = bus.req0_data_i; s[0] = bus.req0_swap_i; l[0] = bus.req0_last_i;
        v[1] = bus.req1_valid_i; d[1] = bus.req1_data_i; s[1] = bus.req1_swap_i; l[1] = bus.req1_last_i;
        sf = !m_ov || bus.out_ready_i;
        if (m_lock >= 0) own = m_lock;
        else if (v[0] && v[1]) own = m_last ? 0 : 1;
        else if (v[0]) own = 0;
        else if (v[1]) own = 1;
        else own = -1;
        if (!reset) begin
            check("m_ready0", bus.req0_ready_o, sf && own == 0);
            check("m_ready1", bus.req1_ready_o, sf && own == 1);
        end
        check("m_out_valid", bus.out_valid_o, m_ov);
        if (m_ov) begin
            check("m_out_data", bus.out_data_o, m_od);
            check("m_out_src", bus.out_src_o, m_os);
            check("m_out_last", bus.out_last_o, m_ol);
        end
        if (sb_en && bus.out_valid_o && bus.out_ready_i) begin
            if (bus.out_src_o ? exp_q1.size() == 0 : exp_q0.size() == 0) begin
                check("sb_unexpected_beat", {63'd0, bus.out_src_o}, 64'hFFFF);
            end else begin
                e = bus.out_src_o ? exp_q1.pop_front() : exp_q0.pop_front();
                check("sb_beat", {bus.out_last_o, bus.out_data_o}, e);
            end
        end
        fire0 = bus.req0_valid_i && bus.req0_ready_o;
        fire1 = bus.req1_valid_i && bus.req1_ready_o;
        if (reset) begin
            m_lock = -1; m_last = 1'b1; m_ov = 1'b0; m_od = '0; m_os = 1'b0; m_ol = 1'b0;
        end else if (sf) begin
            if (own >= 0 && v[own]) begin
                m_ov = 1'b1;
                m_od = s[own] ? rev(d[own]) : d[own];
                m_os = own[0];
                m_ol = l[own];
                m_last = own[0];
                m_lock = l[own] ? -1 : own;
            end else begin
                m_ov = 1'b0;
            end
        end
    end

    task automatic drv(input int n, input logic v, input logic [DW-1:0] d, input logic s, input logic l);
        if (n == 0) begin
            bus.req0_valid_i = v; bus.req0_data_i = d; bus.req0_swap_i = s; bus.req0_last_i = l;
        end else begin
            bus.req1_valid_i = v; bus.req1_data_i = d; bus.req1_swap_i = s; bus.req1_last_i = l;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        drv(0, 1'b0, '0, 1'b0, 1'b0);
        drv(1, 1'b0, '0, 1'b0, 1'b0);
        bus.out_ready_i = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid_o, 1'b0);
        check("rst_out_data", bus.out_data_o, 32'h0);
        check("rst_out_src", bus.out_src_o, 1'b0);
        check("rst_out_last", bus.out_last_o, 1'b0);

        // Single swapped beat, then a pass-through beat from requester 1.
        step();
        drv(0, 1'b1, 32'h11223344, 1'b1, 1'b1);
        @(negedge clk);
        check("t1_ready0", bus.req0_ready_o, 1'b1);
        step();
        drv(0, 1'b0, '0, 1'b0, 1'b0);
        drv(1, 1'b1, 32'hA1B2C3D4, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_valid", bus.out_valid_o, 1'b1);
        check("t1_data", bus.out_data_o, 32'h44332211);
        check("t1_src", bus.out_src_o, 1'b0);
        check("t1_last", bus.out_last_o, 1'b1);
        check("t2_ready1", bus.req1_ready_o, 1'b1);
        step();
        drv(1, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_data", bus.out_data_o, 32'hA1B2C3D4);
        check("t2_src", bus.out_src_o, 1'b1);

        // Round-robin contention from reset: 0,1,0,1 with no bubbles.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drv(0, 1'b1, 32'h01020304, 1'b0, 1'b1);
        drv(1, 1'b1, 32'h05060708, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_ready0", bus.req0_ready_o, (k % 2) == 0);
            check("t3_ready1", bus.req1_ready_o, (k % 2) == 1);
            if (k > 0) begin
                check("t3_valid", bus.out_valid_o, 1'b1);
                check("t3_src", bus.out_src_o, ((k - 1) % 2) == 1);
            end
            step();
        end

        // Packet lock: 3-beat packet from req0 with a bubble; req1 waits throughout.
        drv(0, 1'b1, 32'hC0DE0001, 1'b1, 1'b0);
        drv(1, 1'b1, 32'hBEEF0001, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_b1_ready0", bus.req0_ready_o, 1'b1);
        check("t4_b1_ready1", bus.req1_ready_o, 1'b0);
        step();
        drv(0, 1'b0, 32'hC0DE0002, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_bubble_ready1", bus.req1_ready_o, 1'b0);
        step();
        drv(0, 1'b1, 32'hC0DE0002, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_b2_ready1", bus.req1_ready_o, 1'b0);
        step();
        drv(0, 1'b1, 32'hC0DE0003, 1'b1, 1'b1);
        @(negedge clk);
        check("t4_b3_ready1", bus.req1_ready_o, 1'b0);
        step();
        drv(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_b3_data", bus.out_data_o, 32'h0300DEC0);
        check("t4_req1_granted", bus.req1_ready_o, 1'b1);
        step();
        drv(1, 1'b0, '0, 1'b0, 1'b0);

        // Backpressure: hold for 4 cycles, then drain and load in the same cycle.
        drv(0, 1'b1, 32'h0000AAAA, 1'b0, 1'b1);
        @(negedge clk);
        check("t5_ready0", bus.req0_ready_o, 1'b1);
        step();
        bus.out_ready_i = 1'b0;
        drv(0, 1'b1, 32'h0000BBBB, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_hold_valid", bus.out_valid_o, 1'b1);
            check("t5_hold_data", bus.out_data_o, 32'h0000AAAA);
            check("t5_hold_ready0", bus.req0_ready_o, 1'b0);
            check("t5_hold_ready1", bus.req1_ready_o, 1'b0);
            step();
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("t5_drain_ready0", bus.req0_ready_o, 1'b1);
        step();
        drv(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_new_data", bus.out_data_o, 32'h0000BBBB);
        check("t5_new_valid", bus.out_valid_o, 1'b1);

        // Reset during LOCK1 with a held beat.
        step();
        drv(1, 1'b1, 32'h12345678, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_ready1", bus.req1_ready_o, 1'b1);
        step();
        drv(1, 1'b0, '0, 1'b0, 1'b0);
        bus.out_ready_i = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.out_ready_i = 1'b1;
        drv(0, 1'b1, 32'h22222222, 1'b0, 1'b1);
        drv(1, 1'b1, 32'h33333333, 1'b0, 1'b1);
        @(negedge clk);
        check("t6_out_valid", bus.out_valid_o, 1'b0);
        check("t6_ready0", bus.req0_ready_o, 1'b1);
        check("t6_ready1", bus.req1_ready_o, 1'b0);
        step();
        drv(0, 1'b0, '0, 1'b0, 1'b0);
        drv(1, 1'b0, '0, 1'b0, 1'b0);

        // Randomized packet traffic.
        for (int n = 0; n < 2; n++) begin
            int rem;
            rem = 0;
            for (int i = 0; i < NBEAT; i++) begin
                if (rem == 0) rem = $urandom_range(1, 4);
                bd[n][i] = $urandom;
                bs[n][i] = $urandom_range(0, 1) == 1;
                rem--;
                bl[n][i] = (rem == 0) || (i == NBEAT - 1);
                if (n == 0) exp_q0.push_back({bl[n][i], bs[n][i] ? rev(bd[n][i]) : bd[n][i]});
                else        exp_q1.push_back({bl[n][i], bs[n][i] ? rev(bd[n][i]) : bd[n][i]});
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb_en = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (fire0) idx0++;
            if (fire1) idx1++;
            if (idx0 >= NBEAT && idx1 >= NBEAT && exp_q0.size() == 0 && exp_q1.size() == 0) break;
            if (idx0 < NBEAT) drv(0, $urandom_range(0, 3) != 0, bd[0][idx0], bs[0][idx0], bl[0][idx0]);
            else drv(0, 1'b0, '0, 1'b0, 1'b0);
            if (idx1 < NBEAT) drv(1, $urandom_range(0, 3) != 0, bd[1][idx1], bs[1][idx1], bl[1][idx1]);
            else drv(1, 1'b0, '0, 1'b0, 1'b0);
            bus.out_ready_i = $urandom_range(0, 3) != 0;
            step();
        end
        check("rnd_sent0", idx0, NBEAT);
        check("rnd_sent1", idx1, NBEAT);
        check("rnd_drained0", exp_q0.size(), 0);
        check("rnd_drained1", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
